// File: rtl/mtl2_timer_ctrl.sv
// ---------------------------------------------------------------------------
// mtl2_timer_ctrl
//
// Command-driven Avalon-MM master for a 16-bit interval timer slave.
// A small command port (START / STOP / SNAPSHOT / ACK) is translated into
// fixed bus sequences against the slave register map:
//   0 status (write clears timeout), 1 control {stop,start,cont,ito},
//   2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake; cmd_ready high only in IDLE
//   cmd_op              00 START, 01 STOP, 10 SNAPSHOT, 11 ACK
//   cmd_period          32-bit period for START
//   cmd_cont, cmd_ito   continuous-mode / interrupt-enable for START/STOP
//   rsp_valid/rsp_data  one-cycle snapshot result pulse and held value
//   tick                one-cycle pulse on each rising edge of the irq
//   av_*                Avalon-MM master signals towards the timer slave
//   av_irq              level interrupt from the slave
//
// Build option
//   MTL2_TIMER_AUTO_ACK_EN : when defined, a pending interrupt seen in IDLE
//   is cleared automatically with a status write, ahead of any command.
// ---------------------------------------------------------------------------
module mtl2_timer_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_period,
    input  logic        cmd_cont,
    input  logic        cmd_ito,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        tick,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    input  logic        av_irq
);

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTL,
        WR_SNAP,
        RD_SL,
        RD_SH,
        CAP,
        WR_STAT,
        RSP
    } state_t;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_SNAP  = 2'b10;
    localparam logic [1:0] OP_ACK   = 2'b11;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_PER_L  = 3'd2;
    localparam logic [2:0] REG_PER_H  = 3'd3;
    localparam logic [2:0] REG_SNAP_L = 3'd4;
    localparam logic [2:0] REG_SNAP_H = 3'd5;

    state_t      state_reg;
    state_t      state_next;
    logic [1:0]  op_reg;
    logic [31:0] period_reg;
    logic        cont_reg;
    logic        ito_reg;
    logic        irq_q;
    logic        irq_prev_reg;
    logic        auto_ack;
    logic        accept;
    logic [1:0]  capture_en;

    // ------------------------------------------------------------------
    // Interrupt handling: irq_q is the single registered copy of av_irq;
    // irq_prev_reg only exists to find the rising edge for tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q        <= 1'b0;
            irq_prev_reg <= 1'b0;
        end else begin
            irq_q        <= av_irq;
            irq_prev_reg <= irq_q;
        end
    end

    assign tick = irq_q & ~irq_prev_reg;

`ifdef MTL2_TIMER_AUTO_ACK_EN
    // A pending interrupt in IDLE pre-empts the command port.
    assign auto_ack = irq_q;
`else
    assign auto_ack = 1'b0;
`endif

    assign cmd_ready = (state_reg == IDLE) && !auto_ack;
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (state_reg == RSP);

    // ------------------------------------------------------------------
    // Operand capture on acceptance; held for the whole bus sequence.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_reg     <= OP_START;
            period_reg <= '0;
            cont_reg   <= 1'b0;
            ito_reg    <= 1'b0;
        end else if (accept) begin
            op_reg     <= cmd_op;
            period_reg <= cmd_period;
            cont_reg   <= cmd_cont;
            ito_reg    <= cmd_ito;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (auto_ack) begin
                    state_next = WR_STAT;
                end else if (accept) begin
                    unique case (cmd_op)
                        OP_START: state_next = WR_PL;
                        OP_STOP:  state_next = WR_CTL;
                        OP_SNAP:  state_next = WR_SNAP;
                        OP_ACK:   state_next = WR_STAT;
                        default:  state_next = IDLE;
                    endcase
                end
            end
            WR_PL:   state_next = WR_PH;
            WR_PH:   state_next = WR_CTL;
            WR_CTL:  state_next = IDLE;
            WR_SNAP: state_next = RD_SL;
            RD_SL:   state_next = RD_SH;
            RD_SH:   state_next = CAP;
            CAP:     state_next = RSP;
            RSP:     state_next = IDLE;
            WR_STAT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus drive, decoded straight from state so that reset idles the bus
    // without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        av_chipselect = 1'b0;
        av_write_n    = 1'b1;
        av_address    = 3'd0;
        av_writedata  = 16'd0;
        unique case (state_reg)
            WR_PL: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = REG_PER_L;
                av_writedata  = period_reg[15:0];
            end
            WR_PH: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = REG_PER_H;
                av_writedata  = period_reg[31:16];
            end
            WR_CTL: begin
                // Same state serves START (final step) and STOP.
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = REG_CTRL;
                if (op_reg == OP_STOP) begin
                    av_writedata = {12'd0, 1'b1, 1'b0, cont_reg, ito_reg};
                end else begin
                    av_writedata = {12'd0, 1'b0, 1'b1, cont_reg, ito_reg};
                end
            end
            WR_SNAP: begin
                // Any write to snap_l latches the running counter.
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = REG_SNAP_L;
            end
            RD_SL: begin
                av_chipselect = 1'b1;
                av_address    = REG_SNAP_L;
            end
            RD_SH: begin
                av_chipselect = 1'b1;
                av_address    = REG_SNAP_H;
            end
            WR_STAT: begin
                av_chipselect = 1'b1;
                av_write_n    = 1'b0;
                av_address    = REG_STATUS;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Snapshot result. Slave read data lags the address by one cycle, so
    // the low half lands while snap_h is being addressed (RD_SH) and the
    // high half one cycle later (CAP).
    // ------------------------------------------------------------------
    assign capture_en[0] = (state_reg == RD_SH);
    assign capture_en[1] = (state_reg == CAP);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp_half
            logic [15:0] half_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    half_reg <= 16'd0;
                end else if (capture_en[gi]) begin
                    half_reg <= av_readdata;
                end
            end

            assign rsp_data[gi*16 +: 16] = half_reg;
        end
    endgenerate

endmodule

// File: tb/tb_mtl2_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mtl2_timer_ctrl
//
// Directed bench for mtl2_timer_ctrl. Expected bus transactions, snapshot
// responses and tick pulses are queued (with the cycle they must appear in)
// as stimulus is driven; negedge monitors pop and compare them. A small
// slave model returns registered read data for the snapshot registers.
// Works with or without MTL2_TIMER_AUTO_ACK_EN defined.
// ---------------------------------------------------------------------------
module tb_mtl2_timer_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_period = 32'd0;
    logic        cmd_cont = 1'b0;
    logic        cmd_ito = 1'b0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tick;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata = 16'd0;
    logic        av_irq = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    logic [15:0] snap_l_val = 16'h1234;
    logic [15:0] snap_h_val = 16'h00AB;

    typedef struct {
        int          at;
        logic [2:0]  addr;
        logic        we;
        logic [15:0] data;
    } bus_t;

    typedef struct {
        int          at;
        logic [31:0] data;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   tick_q[$];
    bus_t bus_e;
    rsp_t rsp_e;
    int   tick_e;
    int   t;
    int   c;

    mtl2_timer_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_period    (cmd_period),
        .cmd_cont      (cmd_cont),
        .cmd_ito       (cmd_ito),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .tick          (tick),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_write_n    (av_write_n),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata),
        .av_irq        (av_irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: read data registered, valid the cycle after the address.
    always @(posedge clk) begin
        if (av_chipselect && av_write_n) begin
            if (av_address == 3'd4)      av_readdata <= snap_l_val;
            else if (av_address == 3'd5) av_readdata <= snap_h_val;
            else                         av_readdata <= 16'd0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_bus(input int at, input logic [2:0] a, input logic we, input logic [15:0] d);
        bus_t e;
        e.at = at; e.addr = a; e.we = we; e.data = d;
        bus_q.push_back(e);
    endtask

    task automatic push_rsp(input int at, input logic [31:0] d);
        rsp_t e;
        e.at = at; e.data = d;
        rsp_q.push_back(e);
    endtask

    task automatic push_snap(input int at0, input logic [31:0] d);
        push_bus(at0 + 1, 3'd4, 1'b1, 16'h0000);
        push_bus(at0 + 2, 3'd4, 1'b0, 16'h0000);
        push_bus(at0 + 3, 3'd5, 1'b0, 16'h0000);
        push_rsp(at0 + 5, d);
    endtask

    // Single-cycle command; caller has already queued the expectations.
    task automatic send(input logic [1:0] op, input logic [31:0] per, input logic cont, input logic ito);
        cmd_valid = 1'b1; cmd_op = op; cmd_period = per; cmd_cont = cont; cmd_ito = ito;
        chk("cmd_ready_at_send", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
    endtask

    // Monitors
    always @(negedge clk) begin
        if (mon_en) begin
            if (av_chipselect) begin
                checks++;
                assert (bus_q.size() != 0) else begin
                    failures++;
                    $error("FAIL bus_unexpected: observed addr=%0d write_n=%0b data=0x%0h at cycle %0d expected no transaction",
                           av_address, av_write_n, av_writedata, cyc);
                end
                if (bus_q.size() != 0) begin
                    bus_e = bus_q.pop_front();
                    chk("bus_cycle", cyc, bus_e.at);
                    chk("bus_addr", av_address, bus_e.addr);
                    chk("bus_write_n", av_write_n, !bus_e.we);
                    chk("bus_wdata", av_writedata, bus_e.data);
                end
            end else begin
                chk("bus_idle", {av_address, av_write_n, av_writedata}, {3'd0, 1'b1, 16'd0});
            end
            if (rsp_valid) begin
                checks++;
                assert (rsp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL rsp_unexpected: observed data=0x%0h at cycle %0d expected no response", rsp_data, cyc);
                end
                if (rsp_q.size() != 0) begin
                    rsp_e = rsp_q.pop_front();
                    chk("rsp_cycle", cyc, rsp_e.at);
                    chk("rsp_data", rsp_data, rsp_e.data);
                end
            end
            if (tick) begin
                checks++;
                assert (tick_q.size() != 0) else begin
                    failures++;
                    $error("FAIL tick_unexpected: observed tick at cycle %0d expected none", cyc);
                end
                if (tick_q.size() != 0) begin
                    tick_e = tick_q.pop_front();
                    chk("tick_cycle", cyc, tick_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step(2);
        mon_en = 1'b1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_chipselect", av_chipselect, 1'b0);
        #2 reset_n = 1'b1;
        step(2);

        // START 0x000186A0 cont=1 ito=1
        t = cyc;
        push_bus(t + 1, 3'd2, 1'b1, 16'h86A0);
        push_bus(t + 2, 3'd3, 1'b1, 16'h0001);
        push_bus(t + 3, 3'd1, 1'b1, 16'h0007);
        send(2'b00, 32'h0001_86A0, 1'b1, 1'b1);
        chk("start_ready_t1", cmd_ready, 1'b0);
        step();
        chk("start_ready_t2", cmd_ready, 1'b0);
        step();
        chk("start_ready_t3", cmd_ready, 1'b0);
        step();
        chk("start_ready_t4", cmd_ready, 1'b1);

        // STOP cont=1 ito=0
        t = cyc;
        push_bus(t + 1, 3'd1, 1'b1, 16'h000A);
        send(2'b01, 32'h0, 1'b1, 1'b0);
        chk("stop_ready_t1", cmd_ready, 1'b0);
        step();
        chk("stop_ready_t2", cmd_ready, 1'b1);

        // SNAPSHOT returning 0x1234 / 0x00AB
        t = cyc;
        push_snap(t, 32'h00AB_1234);
        send(2'b10, 32'h0, 1'b0, 1'b0);
        step(5);
        chk("snap_ready_t6", cmd_ready, 1'b1);
        chk("snap_data_after", rsp_data, 32'h00AB_1234);
        step(3);
        chk("snap_data_hold", rsp_data, 32'h00AB_1234);

        // START with period 0, cont=0 ito=0
        t = cyc;
        push_bus(t + 1, 3'd2, 1'b1, 16'h0000);
        push_bus(t + 2, 3'd3, 1'b1, 16'h0000);
        push_bus(t + 3, 3'd1, 1'b1, 16'h0004);
        send(2'b00, 32'h0, 1'b0, 1'b0);
        step(3);

        // SNAPSHOT with cmd_valid held, then a STOP waiting behind it
        snap_l_val = 16'hBEEF;
        snap_h_val = 16'hDEAD;
        t = cyc;
        push_snap(t, 32'hDEAD_BEEF);
        push_bus(t + 7, 3'd1, 1'b1, 16'h0009);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_period = 32'h0; cmd_cont = 1'b0; cmd_ito = 1'b0;
        step();
        cmd_op = 2'b01; cmd_ito = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk("held_ready_low", cmd_ready, 1'b0);
            step();
        end
        chk("held_ready_t6", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        step();

        // Interrupt at cycle 100, ACK requested at 101
        while (cyc < 100) step();
        av_irq = 1'b1;
        tick_q.push_back(cyc + 1);
        c = cyc;
        step();
        av_irq = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_cont = 1'b0; cmd_ito = 1'b0;
`ifdef MTL2_TIMER_AUTO_ACK_EN
        push_bus(c + 2, 3'd0, 1'b1, 16'h0000);
        push_bus(c + 4, 3'd0, 1'b1, 16'h0000);
        chk("irq_ready_t101", cmd_ready, 1'b0);
        step();
        chk("irq_ready_t102", cmd_ready, 1'b0);
        step();
        chk("irq_ready_t103", cmd_ready, 1'b1);
        step();
`else
        push_bus(c + 2, 3'd0, 1'b1, 16'h0000);
        chk("irq_ready_t101", cmd_ready, 1'b1);
        step();
`endif
        cmd_valid = 1'b0;
        step(3);

        // Interrupt held high for four cycles: a single tick
        c = cyc;
        av_irq = 1'b1;
        tick_q.push_back(c + 1);
`ifdef MTL2_TIMER_AUTO_ACK_EN
        push_bus(c + 2, 3'd0, 1'b1, 16'h0000);
        push_bus(c + 4, 3'd0, 1'b1, 16'h0000);
`endif
        step(4);
        av_irq = 1'b0;
        step(4);

        // Reset during WR_PH of a START
        t = cyc;
        push_bus(t + 1, 3'd2, 1'b1, 16'h5678);
        send(2'b00, 32'h1234_5678, 1'b1, 1'b1);
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_chipselect", av_chipselect, 1'b0);
        chk("arst_write_n", av_write_n, 1'b1);
        chk("arst_address", av_address, 3'd0);
        chk("arst_cmd_ready", cmd_ready, 1'b1);
        chk("arst_rsp_data", rsp_data, 32'h0);
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        step(2);
        #2 reset_n = 1'b1;
        step(6);
        chk("post_rst_ready", cmd_ready, 1'b1);

        // Everything queued must have been seen
        chk("bus_q_empty", bus_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);
        chk("tick_q_empty", tick_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mtl2_timer_ctrl.md
MTL2_TIMER_CTRL -- requirements
Module: mtl2_timer_ctrl

Interface
REQ-001 SHALL have these ports: clk, in, 1, clock; all state on rising edge.
REQ-002 SHALL have reset_n, in, 1, reset; asynchronous, active-low.
REQ-003 SHALL have cmd_valid, in, 1, command request.
REQ-004 SHALL have cmd_ready, out, 1, controller can accept a command.
REQ-005 SHALL have cmd_op, in, 2, command: 00 START, 01 STOP, 10 SNAPSHOT, 11 ACK.
REQ-006 SHALL have cmd_period, in, 32, timer period for START.
REQ-007 SHALL have cmd_cont, in, 1, continuous-mode bit for START/STOP.
REQ-008 SHALL have cmd_ito, in, 1, interrupt-enable bit for START/STOP.
REQ-009 SHALL have rsp_valid, out, 1, one-cycle pulse: snapshot result valid.
REQ-010 SHALL have rsp_data, out, 32, snapshot counter value.
REQ-011 SHALL have tick, out, 1, one-cycle pulse per timeout seen.
REQ-012 SHALL have av_address, out, 3, timer slave register index.
REQ-013 SHALL have av_chipselect, out, 1, slave select.
REQ-014 SHALL have av_write_n, out, 1, active-low write.
REQ-015 SHALL have av_writedata, out, 16, write data.
REQ-016 SHALL have av_readdata, in, 16, slave read data; registered by the slave, valid one cycle after address presented.
REQ-017 SHALL have av_irq, in, 1, slave interrupt, level.

Function
REQ-018 SHALL be an Avalon-MM master for the 16-bit interval timer with this register map: 0 status (write clears timeout), 1 control {stop,start,cont,ito}, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
REQ-019 SHALL use FSM states IDLE, WR_PL, WR_PH, WR_CTL, WR_SNAP, RD_SL, RD_SH, CAP, WR_STAT, RSP.
REQ-020 SHALL drive cmd_ready = (state==IDLE), gated per REQ-031 when that feature is present; a command is accepted when cmd_valid && cmd_ready, and the registered operands are captured on acceptance.
REQ-021 SHALL drive the bus idle outside write/read states: chipselect 0, write_n 1, address 0, writedata 0.
REQ-022 SHALL, for START accepted at cycle T, perform these writes, one bus cycle each:
- T+1: addr 2 <= period[15:0]
- T+2: addr 3 <= period[31:16]
- T+3: addr 1 <= {0,1,cont,ito}
- Back in IDLE at T+4.
REQ-023 SHALL, for STOP accepted at T, write addr 1 <= {1,0,cont,ito} at T+1; IDLE at T+2.
REQ-024 SHALL, for ACK accepted at T, write addr 0 <= 0 at T+1; IDLE at T+2.
REQ-025 SHALL, for SNAPSHOT accepted at T, run this sequence:
- T+1: write addr 4 (data 0).
- T+2: read addr 4 (chipselect 1, write_n 1).
- T+3: read addr 5; capture av_readdata into rsp_data[15:0].
- T+4 (CAP): capture av_readdata into rsp_data[31:16].
- T+5: rsp_valid = 1, then IDLE.
REQ-026 SHALL hold rsp_data until the next SNAPSHOT capture; rsp_valid has no backpressure.
REQ-027 SHALL pass period 0 through unmodified; there is no range checking.
REQ-028 SHALL ignore cmd_valid while not IDLE; the command is neither queued nor dropped silently, since cmd_ready is low.
REQ-029 SHALL register av_irq once (irq_q) and pulse tick for one cycle on an irq_q rising edge, independent of FSM state.

Reset
REQ-030 SHALL, while reset_n is low, immediately force the following, including mid-sequence; partial bus sequences are abandoned:
- state IDLE, irq_q 0
- cmd_ready 1, rsp_valid 0, rsp_data 0, tick 0
- bus idle per REQ-021

Configuration
REQ-031 SHALL provide the macro MTL2_TIMER_AUTO_ACK_EN.
- Defined: when IDLE and irq_q is 1, enter WR_STAT and write addr 0 <= 0 next cycle; this takes priority over a concurrent cmd_valid; cmd_ready is 0 in any IDLE cycle with irq_q 1.
- Undefined: no automatic status write; av_irq stays high until the user issues ACK; tick behaviour per REQ-029 is unchanged.

Verification
REQ-032 START period 0x0001_86A0, cont 1, ito 1 -> bus writes in consecutive cycles: (2,0x86A0), (3,0x0001), (1,0x0007); cmd_ready low 3 cycles.
REQ-033 SNAPSHOT with slave model returning 0x1234 at addr 4 and 0x00AB at addr 5 -> rsp_valid pulses at T+5 with rsp_data 0x00AB_1234.
REQ-034 STOP with cont 1, ito 0 -> single write (1,0x000A) at T+1.
REQ-035 av_irq raised at cycle 100 -> tick pulse at 101; with AUTO_ACK_EN, write (0,0x0000) at 102 and cmd_valid held at 101 is accepted only after the ACK completes.
REQ-036 reset_n asserted during WR_PH of START -> bus idle and cmd_ready 1 asynchronously; no control write occurs after release.
REQ-037 cmd_valid held during a SNAPSHOT -> accepted the cycle after rsp_valid, never earlier.
